// File: rtl/response_packer.sv
// Packs pairwise PUF counter comparisons (bit = A > B) into WORD_BITS-wide words
// behind a single-entry valid/ready output register, with a flush on done.
module response_packer #(
    parameter int TOT_CNT_BITS = 32,
    parameter int WORD_BITS    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_puf,
    input  logic                          store_response_puf,
    input  logic [TOT_CNT_BITS-1:0]       puf_response,
    input  logic                          done,
    output logic [WORD_BITS-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(WORD_BITS):0]    out_count,
    output logic                          overflow,
    output logic                          odd_drop
);

    localparam int CW = $clog2(WORD_BITS) + 1;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [TOT_CNT_BITS-1:0]   a_q, a_d;
    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]      acc_q, acc_d;
    logic                      done_prev_q;
    logic                      halted_q, halted_d;
    logic [WORD_BITS-1:0]      out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [CW-1:0]             out_count_q, out_count_d;
    logic                      overflow_q, overflow_d;
    logic                      odd_drop_q, odd_drop_d;

    logic                      done_edge;
    logic                      cap_bit;
    logic                      word_load;
    logic                      word_last;
    logic [WORD_BITS-1:0]      word_bits;
    logic [CW-1:0]             word_cnt;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bit_cnt_d   = bit_cnt_q;
        acc_d       = acc_q;
        halted_d    = halted_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_count_d = out_count_q;
        overflow_d  = overflow_q;
        odd_drop_d  = odd_drop_q;
        cap_bit     = 1'b0;
        word_load   = 1'b0;
        word_last   = 1'b0;

        done_edge = done & ~done_prev_q;

        // The capture is applied first so a coincident flush includes its bit.
        if (store_response_puf && !halted_q) begin
            if (state_q == WAIT_A) begin
                a_d     = puf_response;
                state_d = WAIT_B;
            end else begin
                cap_bit   = (a_q > puf_response);
                acc_d     = acc_q | (WORD_BITS'(cap_bit) << bit_cnt_q);
                bit_cnt_d = bit_cnt_q + CW'(1);
                state_d   = WAIT_A;
            end
        end

        word_bits = acc_d;
        word_cnt  = bit_cnt_d;

        if (done_edge && !halted_q) begin
            if (state_d == WAIT_B) begin
                odd_drop_d = 1'b1;
            end
            state_d   = WAIT_A;
            a_d       = '0;
            word_load = 1'b1;
            word_last = 1'b1;
            bit_cnt_d = '0;
            acc_d     = '0;
            halted_d  = 1'b1;
        end else if (bit_cnt_d == CW'(WORD_BITS)) begin
            word_load = 1'b1;
            bit_cnt_d = '0;
            acc_d     = '0;
        end

        // A word may load only into an empty slot or one being drained this cycle.
        if (word_load) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word_bits;
                out_count_d = word_cnt;
                out_last_d  = word_last;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (start_puf) begin
            state_d     = WAIT_A;
            a_d         = '0;
            bit_cnt_d   = '0;
            acc_d       = '0;
            halted_d    = 1'b0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            odd_drop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_A;
            a_q         <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            done_prev_q <= 1'b0;
            halted_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
            odd_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_q       <= acc_d;
            done_prev_q <= done;
            halted_q    <= halted_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_count_q <= out_count_d;
            overflow_q  <= overflow_d;
            odd_drop_q  <= odd_drop_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_count = out_count_q;
    assign overflow  = overflow_q;
    assign odd_drop  = odd_drop_q;

endmodule

// File: tb/tb_response_packer.sv
// Directed scenarios plus randomized traffic for response_packer (WORD_BITS=8),
// checked against a queue-based behavioural model of the pairing/packing rules.
module tb_response_packer;

    localparam int TCB = 32;
    localparam int WB  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_puf;
    logic            store_response_puf;
    logic [TCB-1:0]  puf_response;
    logic            done;
    logic [WB-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [3:0]      out_count;
    logic            overflow;
    logic            odd_drop;

    response_packer #(.TOT_CNT_BITS(TCB), .WORD_BITS(WB)) dut (
        .clk                (clk),
        .reset              (reset),
        .start_puf          (start_puf),
        .store_response_puf (store_response_puf),
        .puf_response       (puf_response),
        .done               (done),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .out_count          (out_count),
        .overflow           (overflow),
        .odd_drop           (odd_drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit             m_ignore, m_have_a, m_dprev;
    logic [TCB-1:0] m_a;
    bit             m_bits[$];
    logic           m_valid, m_last, m_ovf, m_odd;
    logic [WB-1:0]  m_data;
    int             m_count;

    // Words seen accepted by the consumer: {data, count, last}
    logic [12:0]    acc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit st, input bit str, input logic [TCB-1:0] v,
                              input bit dn, input bit rdy, input bit rst);
        bit            accepted, edge_seen, have_word, w_last;
        logic [WB-1:0] w;
        int            w_cnt;
        if (rst) begin
            m_valid = 0; m_data = '0; m_count = 0; m_last = 0; m_ovf = 0; m_odd = 0;
            m_ignore = 0; m_have_a = 0; m_bits.delete(); m_dprev = 0;
            return;
        end
        if (st) begin
            m_valid = 0; m_ovf = 0; m_odd = 0; m_ignore = 0; m_have_a = 0;
            m_bits.delete(); m_dprev = dn;
            return;
        end
        accepted  = m_valid && rdy;
        edge_seen = dn && !m_dprev;
        m_dprev   = dn;
        have_word = 0;
        w_last    = 0;
        w         = '0;
        w_cnt     = 0;
        if (str && !m_ignore) begin
            if (!m_have_a) begin
                m_a = v; m_have_a = 1;
            end else begin
                m_bits.push_back(m_a > v);
                m_have_a = 0;
            end
        end
        if ((edge_seen && !m_ignore) || m_bits.size() == WB) begin
            have_word = 1;
            w_cnt = m_bits.size();
            for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
            m_bits.delete();
            if (edge_seen && !m_ignore) begin
                w_last = 1;
                if (m_have_a) m_odd = 1;
                m_have_a = 0;
                m_ignore = 1;
            end
        end
        if (have_word) begin
            if (!m_valid || accepted) begin
                m_valid = 1; m_data = w; m_count = w_cnt; m_last = w_last;
            end else begin
                m_ovf = 1;
            end
        end else if (accepted) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit st, input bit str, input logic [TCB-1:0] v,
                        input bit dn, input bit rdy, input bit rst);
        start_puf = st; store_response_puf = str; puf_response = v;
        done = dn; out_ready = rdy; reset = rst;
        if (!rst && out_valid && rdy) acc_log.push_back({out_data, out_count, out_last});
        @(posedge clk);
        model_edge(st, str, v, dn, rdy, rst);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("out_count", 32'(out_count), 32'(m_count));
        check("out_last",  32'(out_last),  32'(m_last));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("odd_drop",  32'(odd_drop),  32'(m_odd));
    endtask

    task automatic pair(input logic [TCB-1:0] a, input logic [TCB-1:0] b, input bit rdy);
        step(0, 1, a, 0, rdy, 0);
        step(0, 1, b, 0, rdy, 0);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 1, 0);
    endtask

    bit dn_lvl;

    initial begin
        reset = 1; start_puf = 0; store_response_puf = 0; puf_response = '0;
        done = 0; out_ready = 0;
        m_ignore = 0; m_have_a = 0; m_dprev = 0; m_a = '0;
        m_valid = 0; m_data = '0; m_count = 0; m_last = 0; m_ovf = 0; m_odd = 0;

        // Reset state
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(out_count), 0);

        // Two alternating words then an empty final word
        step(1, 0, '0, 0, 1, 0);
        acc_log.delete();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) pair(10, 5, 1); else pair(5, 10, 1);
        end
        step(0, 0, '0, 1, 1, 0);
        idles(3);
        check("s1_n", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            check("s1_w0", 32'(acc_log[0]), 32'({8'h55, 4'd8, 1'b0}));
            check("s1_w1", 32'(acc_log[1]), 32'({8'h55, 4'd8, 1'b0}));
            check("s1_w2", 32'(acc_log[2]), 32'({8'h00, 4'd0, 1'b1}));
        end

        // Tie gives 0, full-width compare gives 1
        step(1, 0, '0, 0, 1, 0);
        acc_log.delete();
        pair(7, 7, 1);
        pair(32'hFFFF_FFFF, 0, 1);
        step(0, 0, '0, 1, 1, 0);
        idles(3);
        check("s2_n", acc_log.size(), 1);
        if (acc_log.size() == 1) check("s2_w0", 32'(acc_log[0]), 32'({8'h02, 4'd2, 1'b1}));

        // Backpressure: second word dropped, first held and accepted once
        step(1, 0, '0, 0, 0, 0);
        acc_log.delete();
        for (int i = 0; i < 16; i++) pair(9, 1, 0);
        check("s3_ovf", 32'(overflow), 1);
        check("s3_held", 32'(out_data), 32'h0000_00FF);
        idles(3);
        check("s3_n", acc_log.size(), 1);
        if (acc_log.size() == 1) check("s3_w0", 32'(acc_log[0]), 32'({8'hFF, 4'd8, 1'b0}));

        // Unpaired capture at done
        step(1, 0, '0, 0, 1, 0);
        acc_log.delete();
        step(0, 1, 9, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 4, 0, 1, 0);
        step(0, 0, '0, 1, 1, 0);
        idles(3);
        check("s4_odd", 32'(odd_drop), 1);
        check("s4_n", acc_log.size(), 1);
        if (acc_log.size() == 1) check("s4_w0", 32'(acc_log[0]), 32'({8'h01, 4'd1, 1'b1}));

        // Completing B strobe coincides with the done edge
        step(1, 0, '0, 0, 1, 0);
        acc_log.delete();
        for (int i = 0; i < 7; i++) pair(9, 1, 1);
        step(0, 1, 9, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        idles(4);
        check("s5_n", acc_log.size(), 1);
        if (acc_log.size() == 1) check("s5_w0", 32'(acc_log[0]), 32'({8'hFF, 4'd8, 1'b1}));

        // Reset mid-evaluation leaves no residue
        step(1, 0, '0, 0, 1, 0);
        acc_log.delete();
        for (int i = 0; i < 5; i++) pair(9, 1, 1);
        step(0, 0, '0, 0, 1, 1);
        step(1, 0, '0, 0, 1, 0);
        pair(2, 1, 1);
        step(0, 0, '0, 1, 1, 0);
        idles(3);
        check("s6_n", acc_log.size(), 1);
        if (acc_log.size() == 1) check("s6_w0", 32'(acc_log[0]), 32'({8'h01, 4'd1, 1'b1}));

        // Randomized traffic against the model
        dn_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [TCB-1:0] v;
            if ($urandom_range(0, 29) == 0) dn_lvl = ~dn_lvl;
            v = ($urandom_range(0, 3) == 0) ? TCB'($urandom) : TCB'($urandom_range(0, 7));
            step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), v, dn_lvl,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/response_packer.md
RESPONSE_PACKER -- requirements
Module: response_packer

Interface
REQ-001 SHALL have parameter TOT_CNT_BITS, default 32, width of each PUF counter response.
REQ-002 SHALL have parameter WORD_BITS, default 32, response bits per output word (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_puf  input  1  one-cycle pulse; begins a new challenge evaluation, clears packer state.
REQ-006 SHALL have port store_response_puf  input  1  one-cycle strobe; puf_response valid this cycle.
REQ-007 SHALL have port puf_response  input  TOT_CNT_BITS  loop counter value from PUF core.
REQ-008 SHALL have port done  input  1  PUF evaluation complete (level; edge-detected internally).
REQ-009 SHALL have port out_data  output  WORD_BITS  packed response bits, LSB = oldest bit.
REQ-010 SHALL have port out_valid  output  1  out_data/out_last/out_count valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-012 SHALL have port out_last  output  1  word is final word of current evaluation.
REQ-013 SHALL have port out_count  output  $clog2(WORD_BITS)+1  number of valid bits in out_data.
REQ-014 SHALL have port overflow  output  1  sticky; a word was dropped due to backpressure.
REQ-015 SHALL have port odd_drop  output  1  sticky; evaluation ended with an unpaired capture.

Function
REQ-016 SHALL pair captures: states WAIT_A, WAIT_B; store_response_puf in WAIT_A latches puf_response into reg A, goes WAIT_B; in WAIT_B compares, goes WAIT_A.
REQ-017 SHALL produce bit = 1 iff A > B (unsigned, full TOT_CNT_BITS); tie A == B gives 0.
REQ-018 SHALL shift each bit into position bit_cnt of the accumulating word, bit_cnt incrementing 0..WORD_BITS-1; unused upper bits of out_data are 0.
REQ-019 SHALL, on the same clock edge that sampled the completing B strobe, load the full word into the output register (out_valid=1, out_count=WORD_BITS, out_last=0) and reset bit_cnt to 0.
REQ-020 SHALL hold out_data/out_count/out_last stable while out_valid && !out_ready; out_valid falls on the edge after acceptance unless a new word loads on that same edge.
REQ-021 SHALL, if a word completes while the output register is occupied and not accepted that cycle, drop the new word, set overflow, and continue packing.
REQ-022 SHALL detect done rising edge (done=1, prior sample 0); on it: if in WAIT_B discard A and set odd_drop; emit final word with out_count=bit_cnt (0..WORD_BITS-1, or WORD_BITS if the flush coincides with completion), out_last=1; return to WAIT_A, bit_cnt=0.
REQ-023 SHALL, when store_response_puf and done edge occur in the same cycle, process the capture first, then flush including that bit.
REQ-024 SHALL treat the final-word load under REQ-021 backpressure identically (drop, set overflow).
REQ-025 SHALL, on start_puf, clear A, bit_cnt, accumulating word, out_valid, overflow, odd_drop, state=WAIT_A; start_puf wins over any coincident strobe or done edge.
REQ-026 SHALL ignore store_response_puf strobes received after a done edge until the next start_puf.

Reset
REQ-027 SHALL, while reset=1 at a clock edge, force out_valid=0, out_data=0, out_last=0, out_count=0, overflow=0, odd_drop=0, state=WAIT_A, bit_cnt=0, done edge detector prior sample=0, accepting strobes; reset has priority over all inputs.
REQ-028 SHALL, on reset mid-evaluation, discard all partial and pending data with no output word.

Verification (WORD_BITS=8, TOT_CNT_BITS=32)
REQ-029 SHALL cover: start, 16 strobes pairs (10,5),(5,10)x alternating, out_ready=1 -> two words 0x55, out_count=8; then done -> word 0x00, out_count=0, out_last=1.
REQ-030 SHALL cover: pairs (7,7),(0xFFFFFFFF,0) then done -> single word 0x02, out_count=2, out_last=1.
REQ-031 SHALL cover: out_ready=0, 16 pairs all A>B -> first word 0xFF held, second dropped, overflow=1; release ready -> 0xFF accepted once.
REQ-032 SHALL cover: 3 strobes (9,1,4) then done -> word 0x01, out_count=1, out_last=1, odd_drop=1.
REQ-033 SHALL cover: 8th B strobe coincident with done edge -> one word out_count=8, out_last=1; no extra empty word.
REQ-034 SHALL cover: reset asserted after 5 pairs, then start and 1 pair (2,1) and done -> only word 0x01, out_count=1; no residue of prior bits.
